trp_unit_nxn: RTL and testbench

Parametrised next-generation transpose/reduction unit for the vector lane datapath. It accepts a serial stream of DATA_WIDTH elements and operates in one of two ways. In transpose mode it buffers an N x N tile row-major and drains it column-major. In reduction modes it folds N elements into one scalar with add, max or min. Explicit valid/ready handshakes on input and output replace the fire-and-forget enable of the fixed 8-bit unit, plus a synchronous abort.

---
 rtl/trp_pkg.sv | 23 ++
 rtl/trp_reduce_acc.sv | 60 ++++++
 rtl/trp_unit_nxn.sv | 194 +++++++++++++++++++
 tb/tb_trp_unit_nxn.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trp_pkg
// Brief    : Mode and FSM state encodings shared by the transpose/reduce unit.
// Revision : 1.0 - initial release
// ============================================================================
package trp_pkg;

  typedef enum logic [1:0] {
    TRP_ADD       = 2'b00,
    TRP_MAX       = 2'b01,
    TRP_MIN       = 2'b10,
    TRP_TRANSPOSE = 2'b11
  } trp_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    DRAIN = 2'b10
  } trp_state_e;

endpackage
`default_nettype wire

// File: rtl/trp_reduce_acc.sv
`default_nettype none
// ============================================================================
// Module   : trp_reduce_acc
// Brief    : Combinational fold of accumulator and new element (add/max/min).
//            TRP_SIGNED_EN selects signed compare and saturating add.
// Revision : 1.0 - initial release
// ============================================================================
module trp_reduce_acc
  import trp_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  trp_mode_e              mode,
  input  logic [DATA_WIDTH-1:0]  acc,
  input  logic [DATA_WIDTH-1:0]  elem,
  output logic [DATA_WIDTH-1:0]  res
);

  logic [DATA_WIDTH-1:0] sum_res;
  logic                  elem_gt;
  logic                  elem_lt;

`ifdef TRP_SIGNED_EN
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH:0] sum_ext;

  // One extra sign bit: overflow shows up as the top two bits disagreeing.
  always_comb begin
    sum_ext = {acc[DATA_WIDTH-1], acc} + {elem[DATA_WIDTH-1], elem};
    if (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1]) begin
      sum_res = sum_ext[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      sum_res = sum_ext[DATA_WIDTH-1:0];
    end
    elem_gt = $signed(elem) > $signed(acc);
    elem_lt = $signed(elem) < $signed(acc);
  end
`else
  always_comb begin
    sum_res = acc + elem;
    elem_gt = elem > acc;
    elem_lt = elem < acc;
  end
`endif

  // Strict compares so ties keep the existing accumulator value.
  always_comb begin
    res = acc;
    case (mode)
      TRP_ADD: res = sum_res;
      TRP_MAX: if (elem_gt) res = elem;
      TRP_MIN: if (elem_lt) res = elem;
      default: res = acc;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/trp_unit_nxn.sv
`default_nettype none
// ============================================================================
// Module   : trp_unit_nxn
// Brief    : N x N tile transpose or N-element add/max/min reduction with
//            valid/ready handshakes and synchronous abort.
//            Optional macro TRP_SIGNED_EN: signed compare, saturating add.
// Revision : 1.0 - initial release
// ============================================================================
module trp_unit_nxn
  import trp_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int N          = 4,
  localparam int CNT_W      = $clog2(N*N)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [1:0]            mode,
  output logic                  in_ready,
  input  logic                  abort,
  input  logic                  read,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  busy
);

  localparam int RC_W = $clog2(N);

  trp_state_e            state_q, state_d;
  trp_mode_e             mode_q, mode_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [RC_W-1:0]       row_q, row_d;
  logic [RC_W-1:0]       col_q, col_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;

  logic [DATA_WIDTH-1:0] tile_q [N*N];
  logic                  tile_we;
  logic [CNT_W-1:0]      tile_waddr;

  logic                  accept;
  logic                  is_trp;
  logic                  load_last;
  logic                  xfer;
  logic                  drain_last;
  logic [RC_W-1:0]       next_row;
  logic [RC_W-1:0]       next_col;
  logic [CNT_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] acc_next;

  trp_reduce_acc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_reduce_acc (
    .mode (mode_q),
    .acc  (acc_q),
    .elem (a),
    .res  (acc_next)
  );

  always_comb begin
    accept     = en && in_ready;
    is_trp     = (mode_q == TRP_TRANSPOSE);
    load_last  = (state_q == LOAD) && accept &&
                 (is_trp ? (cnt_q == CNT_W'(N*N-1)) : (cnt_q == CNT_W'(N-1)));
    xfer       = (state_q == DRAIN) && read && valid_q;
    drain_last = is_trp ? ((row_q == RC_W'(N-1)) && (col_q == RC_W'(N-1))) : 1'b1;
    // Drain walks column-major: row is the fast index.
    next_row   = (row_q == RC_W'(N-1)) ? '0 : row_q + 1'b1;
    next_col   = (row_q == RC_W'(N-1)) ? col_q + 1'b1 : col_q;
    rd_idx     = CNT_W'(int'(next_row) * N + int'(next_col));
    tile_we    = accept && !abort;
    tile_waddr = (state_q == IDLE) ? '0 : cnt_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = LOAD;
        LOAD:    if (load_last) state_d = DRAIN;
        DRAIN:   if (xfer && drain_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = (state_q != DRAIN);
    busy     = (state_q != IDLE);
    valid    = valid_q;
    out      = out_q;
  end

  always_comb begin
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    acc_d   = acc_q;
    valid_d = valid_q;
    out_d   = out_q;
    if (abort) begin
      cnt_d   = '0;
      row_d   = '0;
      col_d   = '0;
      acc_d   = '0;
      valid_d = 1'b0;
      out_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            mode_d = trp_mode_e'(mode);
            acc_d  = a;
            cnt_d  = CNT_W'(1);
          end
        end
        LOAD: begin
          if (accept) begin
            acc_d = acc_next;
            if (load_last) begin
              cnt_d   = '0;
              valid_d = 1'b1;
              out_d   = is_trp ? tile_q[0] : acc_next;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (drain_last) begin
              row_d   = '0;
              col_d   = '0;
              acc_d   = '0;
              valid_d = 1'b0;
              out_d   = '0;
            end else begin
              row_d = next_row;
              col_d = next_col;
              out_d = tile_q[rd_idx];
            end
          end
        end
        default: begin
          valid_d = 1'b0;
          out_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_q  <= TRP_ADD;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  // Tile storage carries no reset; it is always fully rewritten before a drain.
  always_ff @(posedge clk) begin
    if (tile_we) begin
      tile_q[tile_waddr] <= a;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trp_unit_nxn.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_trp_unit_nxn
// Brief    : Scoreboard bench for trp_unit_nxn (N=4, DATA_WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_trp_unit_nxn;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int NN = N * N;

  logic          clk    = 1'b0;
  logic          resetn = 1'b0;
  logic          en     = 1'b0;
  logic [DW-1:0] a      = '0;
  logic [1:0]    mode   = 2'b00;
  logic          abort  = 1'b0;
  logic          read   = 1'b0;
  logic          in_ready;
  logic          valid;
  logic [DW-1:0] out;
  logic          busy;

  int            tests = 0;
  int            fails = 0;
  int            read_mode = 1;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] stim [NN];

  always #5 clk = ~clk;

  trp_unit_nxn #(
    .DATA_WIDTH (DW),
    .N          (N)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .en       (en),
    .a        (a),
    .mode     (mode),
    .in_ready (in_ready),
    .abort    (abort),
    .read     (read),
    .valid    (valid),
    .out      (out),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every presented transfer.
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_out  = '0;
  always @(negedge clk) begin
    if (resetn) begin
      if (!valid) check("out_zero_when_invalid", out, 0);
      if (valid && prev_hold) check("out_stable_while_stalled", out, prev_out);
      if (valid && read) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got %0d, expected no output", out);
        end else begin
          check("drain_out", out, exp_q.pop_front());
        end
      end
      prev_hold = valid && !read;
      prev_out  = out;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (read_mode)
      0:       read = 1'b0;
      1:       read = 1'b1;
      default: read = 1'($urandom_range(1, 0));
    endcase
  endtask

  task automatic wait_ready();
    int c = 0;
    while (!in_ready && c < 200) begin
      tick();
      c++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout: in_ready=%0d, expected 1", in_ready);
    end
  endtask

  task automatic feed(input logic [1:0] m, input int cnt, input int sw_at,
                      input logic [1:0] m2, input int max_gap);
    for (int i = 0; i < cnt; i++) begin
      if (max_gap > 0) begin
        en = 1'b0;
        repeat ($urandom_range(max_gap, 0)) tick();
      end
      mode = (sw_at >= 0 && i >= sw_at) ? m2 : m;
      en   = 1'b1;
      a    = stim[i];
      wait_ready();
      tick();
    end
    en = 1'b0;
  endtask

  // Reference: transpose reads column-major; reductions fold stepwise.
  function automatic void model_push(input logic [1:0] m);
    int          acc;
    int          v;
    logic [31:0] t;
    if (m == 2'b11) begin
      for (int c = 0; c < N; c++)
        for (int r = 0; r < N; r++)
          exp_q.push_back(stim[r*N + c]);
    end else begin
      acc = 0;
      for (int i = 0; i < N; i++) begin
`ifdef TRP_SIGNED_EN
        v = int'($signed(stim[i]));
`else
        v = int'(stim[i]);
`endif
        if (i == 0) acc = v;
        else if (m == 2'b00) begin
          acc = acc + v;
`ifdef TRP_SIGNED_EN
          if (acc > (2**(DW-1)) - 1) acc = (2**(DW-1)) - 1;
          if (acc < -(2**(DW-1)))    acc = -(2**(DW-1));
`else
          acc = acc % (2**DW);
`endif
        end
        else if (m == 2'b01) begin if (v > acc) acc = v; end
        else begin if (v < acc) acc = v; end
      end
      t = acc;
      exp_q.push_back(t[DW-1:0]);
    end
  endfunction

  task automatic drain_wait();
    int c = 0;
    read_mode = 1;
    while ((exp_q.size() != 0 || busy) && c < 500) begin
      tick();
      c++;
    end
    if (exp_q.size() != 0 || busy) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: pending=%0d busy=%0d, expected 0 0", exp_q.size(), busy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] m;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out", out, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    tick();

    // Transpose 0..15, back-to-back drain
    read_mode = 1;
    for (int i = 0; i < NN; i++) stim[i] = DW'(i);
    feed(2'b11, NN, -1, 2'b11, 0);
    model_push(2'b11);
    @(negedge clk);
    check("tp_latency_valid", valid, 1);
    repeat (NN) tick();
    @(negedge clk);
    check("tp_end_valid", valid, 0);
    check("tp_end_busy", busy, 0);
    check("tp_end_in_ready", in_ready, 1);
    check("tp_all_drained", exp_q.size(), 0);
    tick();

    // Add-reduce with a stalled consumer and ignored en pulses
    read_mode = 0;
    read = 1'b0;
    stim[0] = 8'd200; stim[1] = 8'd100; stim[2] = 8'd3; stim[3] = 8'd4;
    feed(2'b00, N, -1, 2'b00, 0);
    model_push(2'b00);
    for (int k = 0; k < 5; k++) begin
      en = k[0] ? 1'b0 : 1'b1;
      a  = DW'($urandom);
      @(negedge clk);
      check("add_hold_valid", valid, 1);
      check("add_hold_out", out, 51);
      check("add_hold_in_ready", in_ready, 0);
      tick();
    end
    en = 1'b0;
    read = 1'b1;
    drain_wait();

    // Max then min of 7,250,3,9
    stim[0] = 8'd7; stim[1] = 8'd250; stim[2] = 8'd3; stim[3] = 8'd9;
    feed(2'b01, N, -1, 2'b01, 0);
    model_push(2'b01);
    drain_wait();
    feed(2'b10, N, -1, 2'b10, 0);
    model_push(2'b10);
    drain_wait();

    // Mode change after the second element of a transpose tile
    for (int i = 0; i < NN; i++) stim[i] = DW'($urandom);
    feed(2'b11, NN, 2, 2'b00, 0);
    model_push(2'b11);
    drain_wait();

    // Asynchronous reset in the middle of a load
    for (int i = 0; i < NN; i++) stim[i] = DW'(16 + i);
    feed(2'b11, 7, -1, 2'b11, 0);
    check("busy_mid_load", busy, 1);
    #2 resetn = 1'b0;
    #1;
    check("midrst_valid", valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out", out, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    tick();
    feed(2'b11, NN, -1, 2'b11, 0);
    model_push(2'b11);
    drain_wait();

    // Abort in the third drain cycle, then a fresh add-reduce
    for (int i = 0; i < NN; i++) stim[i] = DW'($urandom);
    feed(2'b11, NN, -1, 2'b11, 0);
    model_push(2'b11);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_valid", valid, 0);
    check("abort_busy", busy, 0);
    tick();
    for (int i = 0; i < N; i++) stim[i] = 8'd1;
    feed(2'b00, N, -1, 2'b00, 0);
    model_push(2'b00);
    drain_wait();

    // Randomized tiles, gaps and consumer stalls
    for (int t = 0; t < 25; t++) begin
      m = 2'($urandom_range(3, 0));
      for (int i = 0; i < NN; i++) stim[i] = DW'($urandom);
      read_mode = 2;
      feed(m, (m == 2'b11) ? NN : N, 1, 2'($urandom_range(3, 0)), 2);
      model_push(m);
    end
    drain_wait();
    @(negedge clk);
    check("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
